// File: rtl/banco_reg_2r1w_if.sv
// Bus bundle for the dual-read register bank with pending scoreboard.
// The master side is the control unit; the slave side is the bank.
interface banco_reg_2r1w_if #(
   parameter int WIDTH  = 16,
   parameter int ADDR_W = 3
);
   localparam int DEPTH = 2**ADDR_W;

   logic              w;
   logic [ADDR_W-1:0] w_addr;
   logic [WIDTH-1:0]  w_data;
   logic              ra_en;
   logic [ADDR_W-1:0] ra_addr;
   logic [WIDTH-1:0]  ra_data;
   logic              pend_a;
   logic              rb_en;
   logic [ADDR_W-1:0] rb_addr;
   logic [WIDTH-1:0]  rb_data;
   logic              pend_b;
   logic              rsv_en;
   logic [ADDR_W-1:0] rsv_addr;
   logic              rsv_ack;
   logic              rsv_err;
   logic [DEPTH-1:0]  pend_mask;
   logic [ADDR_W:0]   pend_cnt;

   modport master (
      output w, w_addr, w_data, ra_en, ra_addr, rb_en, rb_addr, rsv_en, rsv_addr,
      input  ra_data, pend_a, rb_data, pend_b, rsv_ack, rsv_err, pend_mask, pend_cnt
   );

   modport slave (
      input  w, w_addr, w_data, ra_en, ra_addr, rb_en, rb_addr, rsv_en, rsv_addr,
      output ra_data, pend_a, rb_data, pend_b, rsv_ack, rsv_err, pend_mask, pend_cnt
   );
endinterface

// File: rtl/banco_reg_2r1w.sv
// DEPTH x WIDTH register bank, one write port, two registered read ports, and a
// per-register pending scoreboard. Define BANCOREG_BYPASS_EN for write-first reads.
module banco_reg_2r1w #(
   parameter int WIDTH  = 16,
   parameter int ADDR_W = 3
) (
   input logic              clock,
   input logic              reset,
   banco_reg_2r1w_if.slave  bus
);
   localparam int DEPTH = 2**ADDR_W;
   localparam int CNT_W = ADDR_W + 1;

   logic [WIDTH-1:0] regs [DEPTH];
   logic [DEPTH-1:0] pend_p0;
   logic [CNT_W-1:0] cnt_p0;
   logic             ack_p0;
   logic             err_p0;
   logic [WIDTH-1:0] ra_data_p0;
   logic [WIDTH-1:0] rb_data_p0;
   logic             pend_a_p0;
   logic             pend_b_p0;

   logic [DEPTH-1:0] pend_clr;
   logic [DEPTH-1:0] pend_next;
   logic             accept;
   logic             reject;
   logic             dec;
   logic             hit_a;
   logic             hit_b;

   // Clear-then-reserve: a write and a reserve to the same register hand it over.
   always_comb begin
      pend_clr = pend_p0;
      if (bus.w) pend_clr[bus.w_addr] = 1'b0;
      accept    = bus.rsv_en && !pend_clr[bus.rsv_addr];
      reject    = bus.rsv_en &&  pend_clr[bus.rsv_addr];
      pend_next = pend_clr;
      if (accept) pend_next[bus.rsv_addr] = 1'b1;
      dec = bus.w && pend_p0[bus.w_addr];
   end

   always_comb begin
`ifdef BANCOREG_BYPASS_EN
      hit_a = bus.w && (bus.w_addr == bus.ra_addr);
      hit_b = bus.w && (bus.w_addr == bus.rb_addr);
`else
      hit_a = 1'b0;
      hit_b = 1'b0;
`endif
   end

   // Stage p0: storage, scoreboard and read-port registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
         pend_p0    <= '0;
         cnt_p0     <= '0;
         ack_p0     <= 1'b0;
         err_p0     <= 1'b0;
         ra_data_p0 <= '0;
         rb_data_p0 <= '0;
         pend_a_p0  <= 1'b0;
         pend_b_p0  <= 1'b0;
      end else begin
         if (bus.w) regs[bus.w_addr] <= bus.w_data;
         pend_p0 <= pend_next;
         cnt_p0  <= cnt_p0 + CNT_W'(accept) - CNT_W'(dec);
         ack_p0  <= accept;
         err_p0  <= reject;
         if (bus.ra_en) begin
            ra_data_p0 <= hit_a ? bus.w_data : regs[bus.ra_addr];
            pend_a_p0  <= hit_a ? 1'b0 : pend_p0[bus.ra_addr];
         end
         if (bus.rb_en) begin
            rb_data_p0 <= hit_b ? bus.w_data : regs[bus.rb_addr];
            pend_b_p0  <= hit_b ? 1'b0 : pend_p0[bus.rb_addr];
         end
      end
   end

   assign bus.ra_data   = ra_data_p0;
   assign bus.rb_data   = rb_data_p0;
   assign bus.pend_a    = pend_a_p0;
   assign bus.pend_b    = pend_b_p0;
   assign bus.rsv_ack   = ack_p0;
   assign bus.rsv_err   = err_p0;
   assign bus.pend_mask = pend_p0;
   assign bus.pend_cnt  = cnt_p0;
endmodule
